// File: rtl/conv_1_fsm.sv
`default_nettype none
// ============================================================================
// Module      : conv_1_fsm (plus companion module mult)
// Description : Window generator for the first convolution stage.
//               On data_rdy it captures an IN_SZ x IN_SZ tensor of DATA_W-bit
//               pixels. It then walks a K x K window over the tensor in
//               serpentine order, one window per clock, and presents each
//               window on out_matrix for the external filter multipliers.
//               mult is a zero-latency unsigned DATA_W x DATA_W multiplier.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous, active-high reset
//               data_rdy     - tensor on input_tensor is valid; start a scan
//               input_tensor - input_tensor[row][col] pixels
//               dir          - step code of current window
//                              (001 right, 010 left, 100 down,
//                               111 first window, 000 not scanning)
//               data_done    - one-cycle pulse when the scan has finished
//               out_matrix   - current window, out_matrix[p][q] = T[r+p][c+q]
// Config      : CONV1_CLEAR_ON_DONE_EN - when defined, out_matrix is cleared
//               as the block returns to idle after a scan; otherwise the
//               last window is held until the next scan.
// Revision    : 1.0 - initial release
// ============================================================================

module conv_1_fsm #(
  parameter int DATA_W = 8,
  parameter int IN_SZ  = 8,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_rdy,
  input  logic [DATA_W-1:0] input_tensor [IN_SZ][IN_SZ],
  output logic [2:0]        dir,
  output logic              data_done,
  output logic [DATA_W-1:0] out_matrix [K][K]
);

  localparam int NPOS  = IN_SZ - K + 1;
  localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int IDX_W = (IN_SZ > 1) ? $clog2(IN_SZ) : 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);
  // The final row runs left when it is odd, so the scan ends at column 0.
  localparam logic [POS_W-1:0] LAST_C   = LAST_POS[0] ? '0 : LAST_POS;

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b100;
  localparam logic [2:0] DIR_FIRST = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   r_q, r_d;
  logic [POS_W-1:0]   c_q, c_d;
  logic [2:0]         dir_q, dir_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  t_q   [IN_SZ][IN_SZ];
  logic [DATA_W-1:0]  t_d   [IN_SZ][IN_SZ];
  logic [DATA_W-1:0]  win_q [K][K];
  logic [DATA_W-1:0]  win_d [K][K];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    t_d     = t_q;
    win_d   = win_q;

    case (state_q)
      S_SCAN: begin
        if (r_q == LAST_POS && c_q == LAST_C) begin
          // Window stays on the last position while data_done pulses.
          state_d = S_DONE;
          done_d  = 1'b1;
          dir_d   = DIR_NONE;
        end else begin
          if (!r_q[0]) begin
            if (c_q != LAST_POS) begin
              c_d   = c_q + POS_W'(1);
              dir_d = DIR_RIGHT;
            end else begin
              r_d   = r_q + POS_W'(1);
              dir_d = DIR_DOWN;
            end
          end else begin
            if (c_q != '0) begin
              c_d   = c_q - POS_W'(1);
              dir_d = DIR_LEFT;
            end else begin
              r_d   = r_q + POS_W'(1);
              dir_d = DIR_DOWN;
            end
          end
          for (int p = 0; p < K; p++) begin
            for (int q = 0; q < K; q++) begin
              win_d[p][q] = t_q[IDX_W'(r_d) + IDX_W'(p)][IDX_W'(c_d) + IDX_W'(q)];
            end
          end
        end
      end

      // DONE lasts exactly the data_done cycle; its exit edge is the first
      // edge at which a new request may be taken, so it shares the start
      // logic with IDLE.
      S_IDLE, S_DONE: begin
        dir_d = DIR_NONE;
        if (data_rdy) begin
          state_d = S_SCAN;
          r_d     = '0;
          c_d     = '0;
          dir_d   = DIR_FIRST;
          t_d     = input_tensor;
          // First window comes straight from the input, not from T.
          for (int p = 0; p < K; p++) begin
            for (int q = 0; q < K; q++) begin
              win_d[p][q] = input_tensor[p][q];
            end
          end
        end else begin
          state_d = S_IDLE;
`ifdef CONV1_CLEAR_ON_DONE_EN
          if (state_q == S_DONE) begin
            for (int p = 0; p < K; p++) begin
              for (int q = 0; q < K; q++) begin
                win_d[p][q] = '0;
              end
            end
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      dir_q   <= DIR_NONE;
      done_q  <= 1'b0;
      for (int i = 0; i < IN_SZ; i++) begin
        for (int j = 0; j < IN_SZ; j++) begin
          t_q[i][j] <= '0;
        end
      end
      for (int p = 0; p < K; p++) begin
        for (int q = 0; q < K; q++) begin
          win_q[p][q] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      for (int i = 0; i < IN_SZ; i++) begin
        for (int j = 0; j < IN_SZ; j++) begin
          t_q[i][j] <= t_d[i][j];
        end
      end
      for (int p = 0; p < K; p++) begin
        for (int q = 0; q < K; q++) begin
          win_q[p][q] <= win_d[p][q];
        end
      end
    end
  end

  assign dir        = dir_q;
  assign data_done  = done_q;
  assign out_matrix = win_q;

endmodule

// ============================================================================
// Module      : mult
// Description : Combinational unsigned multiplier, full-width product.
// Ports       : A, B - operands; Out - A*B
// Revision    : 1.0 - initial release
// ============================================================================
module mult #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic [2*DATA_W-1:0] Out
);

  assign Out = (2*DATA_W)'(A) * (2*DATA_W)'(B);

endmodule

`default_nettype wire

// File: tb/tb_conv_1_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_1_fsm
// Description : Self-checking bench for conv_1_fsm and mult. A reference
//               model derives each window position and step code from the
//               window index and compares the DUT cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_1_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_rdy;
  logic [7:0] tin [8][8];
  logic [2:0] dir;
  logic       data_done;
  logic [7:0] om  [3][3];

  always #5 clk = ~clk;

  conv_1_fsm #(.DATA_W(8), .IN_SZ(8), .K(3)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .data_rdy     (data_rdy),
    .input_tensor (tin),
    .dir          (dir),
    .data_done    (data_done),
    .out_matrix   (om)
  );

  // Filter bank f[p][q] = p+q
  logic [15:0] prod [3][3];
  for (genvar p = 0; p < 3; p++) begin : g_row
    for (genvar q = 0; q < 3; q++) begin : g_col
      mult #(.DATA_W(8)) u_m (.A(om[p][q]), .B(8'(p + q)), .Out(prod[p][q]));
    end
  end

  logic [7:0]  ma, mb;
  logic [15:0] mo;
  mult #(.DATA_W(8)) u_mc (.A(ma), .B(mb), .Out(mo));

  int passed = 0;
  int total  = 0;
  logic [7:0] mt [8][8];   // model copy of the captured tensor

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] got_win();
    logic [71:0] v = '0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        v[(p*3+q)*8 +: 8] = om[p][q];
    return v;
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v = '0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        v[(p*3+q)*8 +: 8] = mt[r+p][c+q];
    return v;
  endfunction

  function automatic logic [71:0] sum_s();
    logic [71:0] s = '0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        s = s + 72'(prod[p][q]);
    return s;
  endfunction

  // Serpentine walk: window k sits on row k/6; even rows count up, odd down.
  function automatic int pos_r(input int k); return k / 6; endfunction
  function automatic int pos_c(input int k);
    return ((k / 6) % 2 == 0) ? (k % 6) : (5 - k % 6);
  endfunction
  function automatic logic [2:0] pos_dir(input int k);
    if (k == 0)          return 3'b111;
    if (k % 6 == 0)      return 3'b100;
    if ((k / 6) % 2 == 0) return 3'b001;
    return 3'b010;
  endfunction

  task automatic load_tensor(input bit ramp);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        tin[i][j] = ramp ? 8'(i + j) : 8'($urandom_range(0, 255));
  endtask

  // Called just after edge N; checks windows 0..35 and the done cycle.
  task automatic scan_body(input bit ramp, input bit scramble);
    for (int k = 0; k < 36; k++) begin
      if (k > 0) tick();
      check($sformatf("dir k=%0d", k), 72'(dir), 72'(pos_dir(k)));
      check($sformatf("win k=%0d", k), got_win(), exp_win(pos_r(k), pos_c(k)));
      check($sformatf("done k=%0d", k), 72'(data_done), 72'(0));
      if (ramp)
        check($sformatf("S k=%0d", k), sum_s(), 72'(18 * (pos_r(k) + pos_c(k)) + 48));
      if (scramble) load_tensor(1'b0);
    end
    tick();  // N+36
    check("done pulse", 72'(data_done), 72'(1));
    check("dir in done", 72'(dir), 72'(0));
    check("win in done", got_win(), exp_win(5, 0));
  endtask

  task automatic start_scan(input bit hold);
    data_rdy = 1'b1;
    mt = tin;
    tick();  // edge N
    if (!hold) data_rdy = 1'b0;
  endtask

  task automatic check_idle_after();
    tick();  // N+37
    check("done cleared", 72'(data_done), 72'(0));
    check("dir idle", 72'(dir), 72'(0));
`ifdef CONV1_CLEAR_ON_DONE_EN
    check("win after done", got_win(), 72'(0));
`else
    check("win after done", got_win(), exp_win(5, 0));
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done stays low", 72'(data_done), 72'(0));
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_rdy = 1'b0;
    load_tensor(1'b0);
    tick();
    tick();
    check("rst dir", 72'(dir), 72'(0));
    check("rst done", 72'(data_done), 72'(0));
    check("rst win", got_win(), 72'(0));
    reset = 1'b0;

    // Idle with data_rdy low
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle dir", 72'(dir), 72'(0));
      check("idle done", 72'(data_done), 72'(0));
      check("idle win", got_win(), 72'(0));
    end

    // Ramp tensor scan with filter sums
    load_tensor(1'b1);
    start_scan(1'b0);
    scan_body(1'b1, 1'b0);
    check_idle_after();

    // Random tensors, input scrambled during the scan
    for (int n = 0; n < 2; n++) begin
      load_tensor(1'b0);
      start_scan(1'b0);
      scan_body(1'b0, 1'b1);
      check_idle_after();
    end

    // data_rdy held high: back-to-back scans, second starts at N+37
    load_tensor(1'b0);
    start_scan(1'b1);
    scan_body(1'b0, 1'b0);
    load_tensor(1'b0);
    mt = tin;
    tick();  // N+37
    data_rdy = 1'b0;
    check("restart dir", 72'(dir), 72'(3'b111));
    check("restart done", 72'(data_done), 72'(0));
    check("restart win", got_win(), exp_win(0, 0));
    scan_body(1'b0, 1'b0);
    check_idle_after();

    // Reset in the middle of a scan
    load_tensor(1'b1);
    start_scan(1'b0);
    for (int k = 1; k < 20; k++) tick();
    check("pre-rst dir", 72'(dir), 72'(pos_dir(19)));
    #2 reset = 1'b1;
    #1;
    check("mid rst dir", 72'(dir), 72'(0));
    check("mid rst done", 72'(data_done), 72'(0));
    check("mid rst win", got_win(), 72'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst no done", 72'(data_done), 72'(0));
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post rst done", 72'(data_done), 72'(0));
      check("post rst dir", 72'(dir), 72'(0));
    end
    start_scan(1'b0);
    scan_body(1'b1, 1'b0);
    check_idle_after();

    // mult corners and a random sample
    ma = 8'd0;   mb = 8'd255; #1 check("mult 0*255", 72'(mo), 72'(0));
    ma = 8'd255; mb = 8'd255; #1 check("mult 255*255", 72'(mo), 72'(65025));
    ma = 8'd3;   mb = 8'd7;   #1 check("mult 3*7", 72'(mo), 72'(21));
    for (int i = 0; i < 8; i++) begin
      ma = 8'($urandom_range(0, 255));
      mb = 8'($urandom_range(0, 255));
      #1 check("mult rand", 72'(mo), 72'(int'(ma) * int'(mb)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
